// File: rtl/accelerator_read_vectors.sv
// Read-vector stage: r(k) = sum_j M(j;k)*w(j) over a column-major streamed memory matrix.
// Define ACCELERATOR_READ_VECTORS_SATURATE_EN to clamp each r(k) instead of wrapping it.
module accelerator_read_vectors #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int MAX_N        = 64
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  output logic                        READY,
  input  logic                        W_IN_J_ENABLE,
  input  logic                        M_IN_J_ENABLE,
  input  logic                        M_IN_K_ENABLE,
  output logic                        W_OUT_J_ENABLE,
  output logic                        M_OUT_J_ENABLE,
  output logic                        R_OUT_K_ENABLE,
  input  logic        [DATA_SIZE-1:0] SIZE_N_IN,
  input  logic        [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic signed [DATA_SIZE-1:0] W_IN,
  input  logic signed [DATA_SIZE-1:0] M_IN,
  output logic signed [DATA_SIZE-1:0] R_OUT
);
  localparam int ACC_W  = 2*DATA_SIZE + CONTROL_SIZE;
  localparam int PROD_W = 2*DATA_SIZE;
  localparam int IDX_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  typedef enum logic [1:0] {STARTER, WEIGHT_LOAD, MATRIX_ACCUMULATE, ENDER} state_t;
  state_t state, state_nxt;

  logic        [CONTROL_SIZE-1:0] n, w, j, k;
  logic signed [DATA_SIZE-1:0]    buffer [MAX_N];
  logic signed [ACC_W-1:0]        acc;

  logic                           accept_w, accept_m, resync, last_w, last_j, last_k;
  logic        [CONTROL_SIZE-1:0] j_eff;
  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        base, sum;

  function automatic logic signed [DATA_SIZE-1:0] fold(input logic signed [ACC_W-1:0] s);
`ifdef ACCELERATOR_READ_VECTORS_SATURATE_EN
    // the sum fits when every bit above the result sign bit repeats the sign
    if (s[ACC_W-1:DATA_SIZE-1] == {(ACC_W-DATA_SIZE+1){s[ACC_W-1]}})
      return s[DATA_SIZE-1:0];
    else if (s[ACC_W-1])
      return {1'b1, {(DATA_SIZE-1){1'b0}}};
    else
      return {1'b0, {(DATA_SIZE-1){1'b1}}};
`else
    return s[DATA_SIZE-1:0];
`endif
  endfunction

  always_comb begin
    accept_w = (state == WEIGHT_LOAD) && W_IN_J_ENABLE;
    accept_m = (state == MATRIX_ACCUMULATE) && M_IN_J_ENABLE;
    // a start-of-column flag mid-column restarts the column at j=0
    resync   = M_IN_K_ENABLE && (j != '0);
    j_eff    = resync ? '0 : j;
    prod     = PROD_W'(M_IN) * PROD_W'(buffer[j_eff[IDX_W-1:0]]);
    base     = resync ? '0 : acc;
    sum      = base + ACC_W'(prod);
    last_w   = (j == n - CONTROL_SIZE'(1));
    last_j   = (j_eff == n - CONTROL_SIZE'(1));
    last_k   = (k == w - CONTROL_SIZE'(1));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STARTER: begin
        if (START) begin
          if (SIZE_N_IN == '0 || SIZE_W_IN == '0) state_nxt = ENDER;
          else                                    state_nxt = WEIGHT_LOAD;
        end
      end
      WEIGHT_LOAD:       if (accept_w && last_w) state_nxt = MATRIX_ACCUMULATE;
      MATRIX_ACCUMULATE: if (accept_m && last_j && last_k) state_nxt = ENDER;
      ENDER:             state_nxt = STARTER;
      default:           state_nxt = STARTER;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= STARTER;
    else     state <= state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      n              <= '0;
      w              <= '0;
      j              <= '0;
      k              <= '0;
      acc            <= '0;
      R_OUT          <= '0;
      R_OUT_K_ENABLE <= 1'b0;
      READY          <= 1'b0;
      W_OUT_J_ENABLE <= 1'b0;
      M_OUT_J_ENABLE <= 1'b0;
    end else begin
      READY          <= (state == ENDER);
      W_OUT_J_ENABLE <= accept_w;
      M_OUT_J_ENABLE <= accept_m;
      R_OUT_K_ENABLE <= accept_m && last_j;
      if (state == STARTER && START) begin
        n   <= (SIZE_N_IN > DATA_SIZE'(MAX_N)) ? CONTROL_SIZE'(MAX_N) : CONTROL_SIZE'(SIZE_N_IN);
        w   <= CONTROL_SIZE'(SIZE_W_IN);
        j   <= '0;
        k   <= '0;
        acc <= '0;
      end
      if (accept_w) j <= last_w ? '0 : j + CONTROL_SIZE'(1);
      if (accept_m) begin
        if (last_j) begin
          R_OUT <= fold(sum);
          acc   <= '0;
          j     <= '0;
          k     <= k + CONTROL_SIZE'(1);
        end else begin
          acc <= sum;
          j   <= j_eff + CONTROL_SIZE'(1);
        end
      end
    end
  end

  // weighting buffer is plain storage; every entry is written before it is read
  always_ff @(posedge CLK) begin
    if (accept_w) buffer[j[IDX_W-1:0]] <= W_IN;
  end
endmodule

// File: tb/tb_accelerator_read_vectors.sv
// Bench for accelerator_read_vectors: directed and random operations checked every cycle
// against a sum-of-products reference computed straight from the read-vector definition.
module tb_accelerator_read_vectors;
  localparam int DS = 8;
  localparam int CS = 16;
  localparam int MN = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start, ready;
  logic                 w_in_j_en, m_in_j_en, m_in_k_en;
  logic                 w_out_j_en, m_out_j_en, r_out_k_en;
  logic        [DS-1:0] size_n, size_w;
  logic signed [DS-1:0] w_in, m_in, r_out;

  int errors = 0;
  int checks = 0;
  logic signed [DS-1:0] r_hold;
  logic signed [DS-1:0] wv [MN];
  logic signed [DS-1:0] mv [MN][MN];

  always #5 clk = ~clk;

  accelerator_read_vectors #(.DATA_SIZE(DS), .CONTROL_SIZE(CS), .MAX_N(MN)) dut (
    .CLK(clk), .RST(rst), .START(start), .READY(ready),
    .W_IN_J_ENABLE(w_in_j_en), .M_IN_J_ENABLE(m_in_j_en), .M_IN_K_ENABLE(m_in_k_en),
    .W_OUT_J_ENABLE(w_out_j_en), .M_OUT_J_ENABLE(m_out_j_en), .R_OUT_K_ENABLE(r_out_k_en),
    .SIZE_N_IN(size_n), .SIZE_W_IN(size_w), .W_IN(w_in), .M_IN(m_in), .R_OUT(r_out)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
    end
  endtask

  function automatic logic signed [DS-1:0] model_r(input longint s);
    longint hi, lo;
    hi = (longint'(1) << (DS-1)) - 1;
    lo = -(longint'(1) << (DS-1));
`ifdef ACCELERATOR_READ_VECTORS_SATURATE_EN
    if (s > hi) return DS'(hi);
    if (s < lo) return DS'(lo);
`endif
    return s[DS-1:0];
  endfunction

  function automatic logic signed [DS-1:0] col_result(input int n, input int k);
    longint s = 0;
    for (int jj = 0; jj < n; jj++) s += longint'(mv[k][jj]) * longint'(wv[jj]);
    return model_r(s);
  endfunction

  task automatic step(input bit er, input logic signed [DS-1:0] erv, input bit erdy,
                      input bit ew, input bit em);
    @(posedge clk);
    @(negedge clk);
    if (er) r_hold = erv;
    chk("r_out_k_enable", r_out_k_en, er);
    chk("r_out", r_out, r_hold);
    chk("ready", ready, erdy);
    chk("w_out_j_enable", w_out_j_en, ew);
    chk("m_out_j_enable", m_out_j_en, em);
  endtask

  task automatic clear_inputs();
    start = 0; w_in_j_en = 0; m_in_j_en = 0; m_in_k_en = 0;
  endtask

  task automatic run_op(input int n_req, input int w_req, input bit rnd, input bit poke_start,
                        input int resync_col, input int abort_at);
    int n, el;
    n = (n_req > MN) ? MN : n_req;
    if (rnd) begin
      for (int jj = 0; jj < MN; jj++) begin
        wv[jj] = DS'($urandom);
        for (int kk = 0; kk < MN; kk++) mv[kk][jj] = DS'($urandom);
      end
    end
    start = 1; size_n = DS'(n_req); size_w = DS'(w_req);
    step(0, 0, 0, 0, 0);
    start = 0;
    if (n == 0 || w_req == 0) begin
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      return;
    end
    for (int jj = 0; jj < n; jj++) begin
      if ($urandom_range(0, 3) == 0) begin
        m_in_j_en = 1; m_in_k_en = 1; m_in = DS'($urandom);
        step(0, 0, 0, 0, 0);
        m_in_j_en = 0; m_in_k_en = 0;
      end
      w_in_j_en = 1; w_in = wv[jj];
      if (poke_start && jj == 0) begin
        start = 1; size_n = 1; size_w = 1;
      end
      step(0, 0, 0, 1, 0);
      start = 0; w_in_j_en = 0;
    end
    el = 0;
    for (int kk = 0; kk < w_req; kk++) begin
      if (kk == resync_col) begin
        m_in_j_en = 1; m_in_k_en = 1; m_in = DS'($urandom);
        step(0, 0, 0, 0, 1);
      end
      for (int jj = 0; jj < n; jj++) begin
        if (el == abort_at) begin
          rst = 1; m_in_j_en = 1; m_in = DS'($urandom);
          @(posedge clk);
          @(negedge clk);
          chk("abort_r_out", r_out, 0);
          chk("abort_r_en", r_out_k_en, 0);
          chk("abort_ready", ready, 0);
          chk("abort_m_en", m_out_j_en, 0);
          rst = 0; clear_inputs(); r_hold = 0;
          step(0, 0, 0, 0, 0);
          step(0, 0, 0, 0, 0);
          return;
        end
        if ($urandom_range(0, 3) == 0) begin
          m_in_j_en = 0; m_in_k_en = 1; w_in_j_en = 1; w_in = DS'($urandom);
          step(0, 0, 0, 0, 0);
          w_in_j_en = 0;
        end
        m_in_j_en = 1; m_in_k_en = (jj == 0); m_in = mv[kk][jj];
        step(jj == n - 1, col_result(n, kk), 0, 0, 1);
        el++;
      end
    end
    m_in_j_en = 0; m_in_k_en = 0;
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; clear_inputs(); size_n = 0; size_w = 0; w_in = 0; m_in = 0; r_hold = 0;
    repeat (2) @(negedge clk);
    chk("reset_r_out", r_out, 0);
    chk("reset_r_en", r_out_k_en, 0);
    chk("reset_ready", ready, 0);
    chk("reset_w_en", w_out_j_en, 0);
    chk("reset_m_en", m_out_j_en, 0);
    rst = 0;
    step(0, 0, 0, 0, 0);

    wv[0] = 1; wv[1] = 2;
    mv[0][0] = 3; mv[0][1] = 4; mv[1][0] = 5; mv[1][1] = 6;
    run_op(2, 2, 0, 0, -1, -1);

    run_op(0, 3, 1, 0, -1, -1);
    run_op(3, 0, 1, 0, -1, -1);

    wv[0] = 100; wv[1] = 100; mv[0][0] = 100; mv[0][1] = 100;
    run_op(2, 1, 0, 0, -1, -1);

    run_op(3, 2, 1, 0, 0, -1);
    run_op(4, 2, 1, 1, -1, -1);
    run_op(11, 2, 1, 0, -1, -1);
    run_op(3, 3, 1, 0, -1, 4);
    run_op(2, 2, 1, 0, -1, -1);

    for (int t = 0; t < 8; t++)
      run_op(int'($urandom_range(1, MN)), int'($urandom_range(1, 4)), 1, 0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
